// File: rtl/run_controller.sv
//-----------------------------------------------------------------------------
// +---------------------------------------------------------------------------+
// | Module   : run_controller                                                 |
// | Purpose  : Run-control FSM for the 9-bit-instruction core. Sequences      |
// |            clear -> hold -> run -> done from the start/done handshake,    |
// |            gates datapath advance with core_en, counts execution cycles   |
// |            (saturating) and forces a finish through a watchdog.           |
// | Ports    : clk         - system clock, rising edge                        |
// |            reset       - asynchronous, active-low                         |
// |            start       - 1 = clear/hold, falling level -> run             |
// |            halt_req    - halt instruction decoded                         |
// |            core_en     - datapath may update this cycle (combinational)   |
// |            core_clear  - one-cycle clear pulse to PC/regfile              |
// |            running     - in RUN                                           |
// |            done        - in DONE, sticky until next start                 |
// |            timeout     - last run ended by watchdog (valid with done)     |
// |            cycle_count - RUN cycles with core_en=1 in current/last run    |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module run_controller #(
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  output logic             core_en,
  output logic             core_clear,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CYC_W-1:0] C_CNT_MAX = '1;
  // Count value on the last permitted RUN cycle; only meaningful when enabled.
  localparam logic [CYC_W-1:0] C_WD_LAST = CYC_W'(TIMEOUT - 1);
  localparam bit               C_WD_EN   = (TIMEOUT != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CYC_W-1:0] r_count;
  logic [CYC_W-1:0] w_count_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             w_advance;
  logic             w_wd_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_timeout_nxt = r_timeout;
    w_advance     = 1'b0;
    w_wd_hit      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CLEAR;
      end

      S_CLEAR: begin
        w_count_nxt   = '0;
        w_timeout_nxt = 1'b0;
        w_state_nxt   = S_HOLD;
      end

      S_HOLD: begin
        // A start glitch here only lengthens HOLD; CLEAR is never re-entered.
        if (!start) w_state_nxt = S_RUN;
      end

      S_RUN: begin
        // The halt instruction itself must not advance the PC or write state.
        w_advance = ~halt_req;
        if (w_advance && (r_count != C_CNT_MAX)) w_count_nxt = r_count + 1'b1;
        // Watchdog fires on the advancing cycle that brings the count to TIMEOUT.
        // Because it requires w_advance, a simultaneous halt always wins.
        w_wd_hit = C_WD_EN && w_advance && (r_count == C_WD_LAST);

        if (start) begin
          w_state_nxt = S_CLEAR;
        end else if (halt_req) begin
          w_state_nxt = S_DONE;
        end else if (w_wd_hit) begin
          w_state_nxt   = S_DONE;
          w_timeout_nxt = 1'b1;
        end
      end

      S_DONE: begin
        if (start) w_state_nxt = S_CLEAR;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign core_en     = w_advance;
  assign core_clear  = (r_state == S_CLEAR);
  assign running     = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign timeout     = r_timeout;
  assign cycle_count = r_count;

endmodule

`default_nettype wire
